// File: rtl/bubble_sort_engine_pkg.sv
// Definitions shared by the sort engines and the OLED bar renderer:
// array geometry and the common sort state encoding.
package sort_defs;

  localparam int NUM_BARS = 10;
  localparam int VAL_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_SWAP    = 2'd2,
    ST_DONE    = 2'd3
  } sort_state_t;

endpackage

// File: rtl/bubble_sort_engine.sv
// Paced bubble sort over a small register array; one compare or one swap per
// step_en pulse so the bar display can show every intermediate arrangement.
module bubble_sort_engine
  import sort_defs::*;
#(
  parameter int N = NUM_BARS,
  parameter int W = VAL_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           step_en,
  input  logic           wr_en,
  input  logic [3:0]     wr_addr,
  input  logic [W-1:0]   wr_data,
  output logic [N*W-1:0] values,
  output logic [3:0]     cur_idx,
  output logic           swap_flag,
  output logic           busy,
  output logic           done,
  output logic [3:0]     pass_cnt
);

  sort_state_t  state, state_nxt;
  logic [W-1:0] vals [N];
  logic [W-1:0] vals_nxt [N];
  logic [3:0]   j, j_nxt, j_p1;
  logic [3:0]   limit, limit_nxt;
  logic [3:0]   pass_cnt_nxt;
  logic         swapped, swapped_nxt;
  logic         advance, pass_had_swap;

  assign j_p1 = j + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      vals     <= '{default: '0};
      j        <= '0;
      limit    <= '0;
      swapped  <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      vals     <= vals_nxt;
      j        <= j_nxt;
      limit    <= limit_nxt;
      swapped  <= swapped_nxt;
      pass_cnt <= pass_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    vals_nxt      = vals;
    j_nxt         = j;
    limit_nxt     = limit;
    swapped_nxt   = swapped;
    pass_cnt_nxt  = pass_cnt;
    advance       = 1'b0;
    pass_had_swap = swapped;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (wr_en && ({1'b0, wr_addr} < 5'(N)))
          vals_nxt[wr_addr] = wr_data;
        if (start) begin
          state_nxt    = ST_COMPARE;
          j_nxt        = '0;
          limit_nxt    = 4'(N - 1);
          swapped_nxt  = 1'b0;
          pass_cnt_nxt = '0;
        end
      end
      ST_COMPARE: begin
        // Strict greater-than keeps equal elements in place.
        if (step_en) begin
          if (vals[j] > vals[j_p1])
            state_nxt = ST_SWAP;
          else
            advance = 1'b1;
        end
      end
      ST_SWAP: begin
        if (step_en) begin
          vals_nxt[j]    = vals[j_p1];
          vals_nxt[j_p1] = vals[j];
          swapped_nxt    = 1'b1;
          pass_had_swap  = 1'b1;
          advance        = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A pass with no swaps proves the array sorted, so stop early.
    if (advance) begin
      if (j < limit - 4'd1) begin
        j_nxt     = j_p1;
        state_nxt = ST_COMPARE;
      end else begin
        pass_cnt_nxt = pass_cnt + 4'd1;
        if (!pass_had_swap || limit == 4'd1) begin
          state_nxt = ST_DONE;
        end else begin
          limit_nxt   = limit - 4'd1;
          j_nxt       = '0;
          swapped_nxt = 1'b0;
          state_nxt   = ST_COMPARE;
        end
      end
    end
  end

  always_comb begin
    values = '0;
    for (int i = 0; i < N; i++)
      values[i*W +: W] = vals[i];
  end

  assign cur_idx   = j;
  assign swap_flag = (state == ST_SWAP);
  assign busy      = (state == ST_COMPARE) || (state == ST_SWAP);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Scoreboard bench for bubble_sort_engine: each sort job pushes its expected
// outcome; a negedge monitor checks results at done plus per-step behaviour.
module tb_bubble_sort_engine;
  import sort_defs::*;

  localparam int N = NUM_BARS;
  localparam int W = VAL_W;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           step_en = 1'b0;
  logic           wr_en = 1'b0;
  logic [3:0]     wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic [N*W-1:0] values;
  logic [3:0]     cur_idx;
  logic           swap_flag;
  logic           busy;
  logic           done;
  logic [3:0]     pass_cnt;

  typedef struct {
    logic [N*W-1:0] sorted;
    int             passes;
    int             steps;
    int             swaps;
  } exp_t;

  exp_t exp_q[$];
  int   cur_arr [N];
  int   n_checks = 0;
  int   n_fail = 0;
  int   run_steps = 0;
  int   run_swaps = 0;

  always #5 clk = ~clk;

  bubble_sort_engine #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .step_en(step_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .values(values), .cur_idx(cur_idx), .swap_flag(swap_flag),
    .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference outcome from counting arguments: swaps equal the inversion count,
  // and the pass count is the largest left-displacement plus one clean pass.
  function automatic exp_t model();
    exp_t e;
    int   q[$];
    int   inv = 0;
    int   maxd = 0;
    int   compares = 0;
    for (int i = 0; i < N; i++) begin
      int d = 0;
      for (int k = 0; k < i; k++)
        if (cur_arr[k] > cur_arr[i]) d++;
      inv += d;
      if (d > maxd) maxd = d;
      q.push_back(cur_arr[i]);
    end
    q.sort();
    e.passes = (maxd + 1 > N - 1) ? N - 1 : maxd + 1;
    for (int p = 1; p <= e.passes; p++) compares += N - p;
    e.steps  = compares + inv;
    e.swaps  = inv;
    e.sorted = '0;
    for (int i = 0; i < N; i++) e.sorted[i*W +: W] = W'(q[i]);
    return e;
  endfunction

  function automatic logic [N*W-1:0] pair_swapped(input logic [N*W-1:0] v, input logic [3:0] k);
    logic [N*W-1:0] r;
    int             a;
    r = v;
    a = int'(k);
    if (a + 1 < N) begin
      r[a*W +: W]     = v[(a+1)*W +: W];
      r[(a+1)*W +: W] = v[a*W +: W];
    end
    return r;
  endfunction

  initial begin : monitor
    logic [N*W-1:0] p_values;
    logic [3:0]     p_idx;
    logic           p_swap, p_step, p_busy, p_done, p_reset;
    bit             have_prev;
    exp_t           e;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (have_prev && !p_reset) begin
        if (p_busy && !p_step)
          checkOutput("hold_between_pulses", 64'({values, swap_flag}), 64'({p_values, p_swap}));
        if (p_busy && p_step && p_swap)
          checkOutput("swap_visible", 64'(values), 64'(pair_swapped(p_values, p_idx)));
        if (swap_flag && !p_swap) run_swaps++;
        if (done && !p_done) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("final_values", 64'(values), 64'(e.sorted));
            checkOutput("pass_cnt", 64'(pass_cnt), 64'(e.passes));
            checkOutput("step_count", 64'(run_steps), 64'(e.steps));
            checkOutput("swap_count", 64'(run_swaps), 64'(e.swaps));
            checkOutput("busy_at_done", 64'(busy), 64'(0));
          end
        end
      end
      if (!reset && !busy && start) begin
        run_steps = 0;
        run_swaps = 0;
      end else if (!reset && busy && step_en) begin
        run_steps++;
      end
      p_values  = values;
      p_idx     = cur_idx;
      p_swap    = swap_flag;
      p_step    = step_en;
      p_busy    = busy;
      p_done    = done;
      p_reset   = reset;
      have_prev = 1;
    end
  end

  // mode 0: step_en held high, 1: every 4th cycle, 2: random,
  // 3: random plus a write and a start attempted mid-sort.
  task automatic applyStimulus(input int mode, input bit write_all);
    int cyc;
    exp_q.push_back(model());
    for (int i = 0; i < N; i++) begin
      if (write_all || i == 0) begin
        @(posedge clk); #2;
        wr_en   = 1'b1;
        wr_addr = 4'(i);
        wr_data = W'(cur_arr[i]);
        start   = (i == N - 1) || !write_all;
      end
    end
    @(posedge clk); #2;
    wr_en = 1'b0;
    start = 1'b0;
    checkOutput("busy_on_start", 64'(busy), 64'(1));
    cyc = 0;
    while (!done && cyc < 4000) begin
      wr_en = 1'b0;
      start = 1'b0;
      case (mode)
        0:       step_en = 1'b1;
        1:       step_en = (cyc % 4 == 3);
        default: step_en = 1'($urandom_range(0, 1));
      endcase
      if (mode == 3 && cyc == 6) begin
        step_en = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = W'(63);
        start   = 1'b1;
      end
      @(posedge clk); #2;
      cyc++;
    end
    step_en = 1'b0;
    wr_en   = 1'b0;
    start   = 1'b0;
    if (!done) checkOutput("done_timeout", 64'(done), 64'(1));
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : driver
    logic [N*W-1:0] ev;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    checkOutput("reset_values", 64'(values), 64'(0));
    checkOutput("reset_flags", 64'({cur_idx, swap_flag, busy, done, pass_cnt}), 64'(0));

    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = W'(55);
    @(posedge clk); #2;
    wr_en = 1'b0;
    checkOutput("oob_write_ignored", 64'(values), 64'(0));
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = W'(7);
    @(posedge clk); #2;
    wr_en = 1'b0;
    ev = '0;
    ev[3*W +: W] = W'(7);
    checkOutput("write_latency", 64'(values), 64'(ev));

    for (int i = 0; i < N; i++) cur_arr[i] = N - 1 - i;
    applyStimulus(0, 1);

    for (int i = 0; i < N; i++) cur_arr[i] = i;
    cur_arr[0] = 63;
    applyStimulus(1, 0);

    for (int i = 0; i < N; i++) cur_arr[i] = i;
    applyStimulus(1, 1);

    cur_arr = '{5, 5, 3, 5, 1, 5, 3, 0, 5, 5};
    applyStimulus(2, 1);

    for (int i = 0; i < N; i++) cur_arr[i] = (i < 3) ? 2 - i : i;
    applyStimulus(1, 1);

    for (int i = 0; i < N; i++) cur_arr[i] = int'($urandom_range(0, 63));
    applyStimulus(3, 1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        cur_arr[i] = (t % 2 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
      applyStimulus(t % 3, 1);
    end

    for (int i = 0; i < N; i++) cur_arr[i] = N - 1 - i;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #2;
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = W'(cur_arr[i]);
    end
    @(posedge clk); #2;
    wr_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #2;
    start   = 1'b0;
    step_en = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("busy_before_reset", 64'(busy), 64'(1));
    reset   = 1'b1;
    step_en = 1'b0;
    @(posedge clk); #2;
    checkOutput("mid_sort_reset_values", 64'(values), 64'(0));
    checkOutput("mid_sort_reset_flags", 64'({cur_idx, swap_flag, busy, done, pass_cnt}), 64'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bubble_sort_engine.md
# bubble_sort_engine

Sequential bubble-sort datapath that holds the array the OLED bar renderer draws. Elements are loaded through a write port, then sorted one compare or swap per `step_en` pulse so every intermediate state stays on screen long enough to see. The block exposes the full array, the active pair index and a swap highlight flag; the bar renderer downstream consumes these outputs directly.

## Interface

**Parameters**
- `N`, default 10: number of elements (bars).
- `W`, default 6: element width; holds bar heights 0..63.

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a sort. Honoured only in IDLE or DONE.
- `step_en`, in, 1: one-cycle pacing pulse from the parent's divider. Advances the sort by one action.
- `wr_en`, in, 1: element write strobe. Honoured only in IDLE or DONE.
- `wr_addr`, in, 4: element index, 0..N-1. Writes with `wr_addr >= N` are ignored.
- `wr_data`, in, W: element value.
- `values`, out, N*W: flattened array; element i is `values[i*W +: W]`.
- `cur_idx`, out, 4: index j of the active pair (j, j+1).
- `swap_flag`, out, 1: high while in SWAP. The renderer uses it to highlight the pair.
- `busy`, out, 1: high in COMPARE or SWAP.
- `done`, out, 1: high in DONE.
- `pass_cnt`, out, 4: number of completed passes.

## Operation

**States.** IDLE, COMPARE, SWAP, DONE.

**IDLE / DONE**
- `wr_en` writes `wr_data` to `values[wr_addr]`.
- `start` enters COMPARE and loads j=0, limit=N-1, pass_swapped=0, pass_cnt=0.

**COMPARE** acts only on `step_en`.
- If `values[j] > values[j+1]`, go to SWAP.
- Otherwise, advance.
- Equal values are never swapped (stable sort).

**SWAP** acts only on `step_en`.
- Exchange `values[j]` and `values[j+1]`.
- Set pass_swapped=1.
- Advance.

**Advance**
- If j < limit-1: j++ and go to COMPARE.
- Otherwise the pass ends and pass_cnt++.
  - If pass_swapped was 0 for the pass (counting this step's swap) or limit==1, go to DONE.
  - Otherwise limit--, j=0, pass_swapped=0, and go to COMPARE.

**Ignored inputs**
- `start` and `wr_en` are ignored while busy.
- `step_en` is ignored in IDLE and DONE.

**Simultaneous events**
- `start` together with `wr_en` in IDLE/DONE: the write lands on the same edge. The sort uses the written value, because no compare happens before the next `step_en`.

**Reset** (including mid-sort, on any edge): state returns to IDLE and `values` are cleared to 0.

**Arithmetic**
- Comparison is unsigned W-bit.
- j, limit and pass_cnt are 4-bit; N ≤ 16 is required.

## Timing

- **Reset values:** all outputs are 0 (`values`=0, `cur_idx`=0, `swap_flag`=0, `busy`=0, `done`=0, `pass_cnt`=0).
- **Registered outputs:** all outputs are registered and change only on the clock edge where the triggering input is sampled high.
- **`start` to busy:** `busy` rises on the edge that samples `start`.
- **Write latency:** `values` reflects a write one edge after `wr_en`.
- **Step timing:**
  - One compare decision or one swap per `step_en` edge.
  - A swap is visible on `values` immediately after its edge.
  - `swap_flag` is high for the whole SWAP dwell: from the compare edge that found an inversion to the swap edge.
- **Completion:** `done` rises on the edge of the final advance. `busy` falls on the same edge.
- **Step count:**
  - The sort costs exactly (compares + swaps) `step_en` pulses.
  - `step_en` held high continuously gives one action per clock.

## Structure

- Shared package/header `sort_defs` holds:
  - `NUM_BARS`=10 and `VAL_W`=6, shared with the bar renderer.
  - The state encodings (IDLE=0, COMPARE=1, SWAP=2, DONE=3), shared with any future sort engines.
- No internal sub-module.
- The step divider `step_pacer` is a separate sibling instantiated by the parent, not inside this block.

## Test plan

- **Reverse order.** Load 9,8,…,0; `start`; hold `step_en` high.
  - Expect exactly 90 steps: 45 compares and 45 swaps.
  - Final `values` = 0..9, `pass_cnt`=9, `done`=1.
- **Already sorted.** Load 0..9; `start`; pulse `step_en`.
  - Expect DONE after 9 pulses, `pass_cnt`=1, `swap_flag` never high.
- **Duplicates.** Load 5,5,3,5,…
  - No swap occurs on any equal pair.
  - Final order is non-decreasing.
- **Pacing.** `step_en` every 4th cycle on input [2,1,0,…].
  - `values` changes only on pulse edges.
  - `swap_flag` is high between the compare edge and the swap edge.
- **Ignored inputs while busy.** `wr_en` and `start` mid-sort are ignored; `values` are unaffected. `reset` asserted mid-sort gives IDLE, all outputs 0, on the next edge.
- **Write bounds and restart.**
  - `wr_addr`=12 leaves the array unchanged.
  - A write then `start` from DONE re-sorts, with `pass_cnt` restarting at 0.
